// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding and default width.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        TRY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_ctrl.sv
// Divider sequencer: state register, iteration counter and phase strobes.
// Run/LoadS are only honoured in IDLE; LoadS wins over Run in the same cycle.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_loads,
    input  logic i_s_zero,
    output logic o_load_s,
    output logic o_ld,
    output logic o_sh,
    output logic o_try,
    output logic o_done,
    output logic o_busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t    r_state;
    div_state_t    w_next;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOAD)
                r_cnt <= '0;
            else if (r_state == TRY)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (!i_loads && i_run) w_next = LOAD;
            LOAD:    w_next = i_s_zero ? DONE : SHIFT;
            SHIFT:   w_next = TRY;
            TRY:     w_next = (r_cnt == CW'(WIDTH - 1)) ? DONE : SHIFT;
            // Run must be seen low before another start is possible.
            DONE:    if (!i_run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_load_s = (r_state == IDLE) && i_loads;
    assign o_ld     = (r_state == LOAD);
    assign o_sh     = (r_state == SHIFT);
    assign o_try    = (r_state == TRY);
    assign o_done   = (r_state == DONE);
    assign o_busy   = (r_state == LOAD) || (r_state == SHIFT) || (r_state == TRY);

endmodule

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider; result 2*WIDTH+1 cycles after the start edge.
// Run-level handshake: Done holds until Run drops; inputs ignored while busy.
module divider_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             LoadS,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    logic [WIDTH-1:0] r_s;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_dbz;

    logic             w_load_s;
    logic             w_ld;
    logic             w_sh;
    logic             w_try;
    logic             w_s_zero;
    logic [WIDTH:0]   w_diff;

    assign w_s_zero = (r_s == '0);
    // Borrow out lands in the top bit: set means A < S, keep A.
    assign w_diff   = r_a - {1'b0, r_s};

    div_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_run    (Run),
        .i_loads  (LoadS),
        .i_s_zero (w_s_zero),
        .o_load_s (w_load_s),
        .o_ld     (w_ld),
        .o_sh     (w_sh),
        .o_try    (w_try),
        .o_done   (Done),
        .o_busy   (Busy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s   <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_dbz <= 1'b0;
        end else begin
            if (w_load_s)
                r_s <= Din;

            if (w_ld) begin
                r_dbz <= w_s_zero;
                if (w_s_zero) begin
                    r_q <= '1;
                    r_a <= {1'b0, Din};
                end else begin
                    r_q <= Din;
                    r_a <= '0;
                end
            end else if (w_sh) begin
                {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
            end else if (w_try) begin
                if (!w_diff[WIDTH]) begin
                    r_a    <= w_diff;
                    r_q[0] <= 1'b1;
                end else begin
                    r_q[0] <= 1'b0;
                end
            end
        end
    end

    assign Q         = r_q;
    assign R         = r_a[WIDTH-1:0];
    assign DivByZero = r_dbz;

endmodule
